// File: rtl/axi_sram_slave_if.sv
// AXI3 slave-side channel bundle for the SRAM slave (AW, W, B, AR, R).
interface axi_sram_slave_if #(
    parameter int unsigned ID_W = 4
) ();
    logic [ID_W-1:0] s_awid;
    logic [31:0]     s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid;
    logic            s_awready;

    logic [ID_W-1:0] s_wid;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;

    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;

    logic [ID_W-1:0] s_arid;
    logic [31:0]     s_araddr;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_arvalid;
    logic            s_arready;

    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready,
        input  s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready,
        output s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a single-port synchronous SRAM,
// one SRAM access per beat.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    axi_sram_slave_if.slave   s,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        StIdle, StWrData, StWrResp, StRdIssue, StRdCap, StRdData
    } state_e;

    state_e            state_q, state_d;
    logic              prio_rd_q, prio_rd_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [7:0]        len_q, len_d;
    logic              fixed_q, fixed_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              sel_rd, sel_wr;
    logic              in_range, id_ok, last_beat;
    logic [ADDR_W-1:0] addr_step;
    logic [8:0]        cnt_inc;

    // prio_rd_q set means a read wins when AW and AR are both valid.
    assign sel_rd    = s.s_arvalid && (prio_rd_q || !s.s_awvalid);
    assign sel_wr    = s.s_awvalid && !sel_rd;
    assign in_range  = cnt_q <= {1'b0, len_q};
    assign id_ok     = s.s_wid == id_q;
    assign last_beat = cnt_q == {1'b0, len_q};
    assign addr_step = fixed_q ? addr_q : addr_q + ADDR_W'(1);
    // Saturate so an over-long write burst never wraps back into range.
    assign cnt_inc   = (cnt_q == 9'h1ff) ? cnt_q : cnt_q + 9'd1;

    assign s.s_bid    = id_q;
    assign s.s_rid    = id_q;
    assign s.s_rdata  = rdata_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = s.s_wdata;

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        id_d      = id_q;
        len_d     = len_q;
        fixed_d   = fixed_q;
        err_d     = err_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;

        s.s_awready = 1'b0;
        s.s_arready = 1'b0;
        s.s_wready  = 1'b0;
        s.s_bvalid  = 1'b0;
        s.s_bresp   = 2'b00;
        s.s_rvalid  = 1'b0;
        s.s_rresp   = 2'b00;
        s.s_rlast   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (sel_rd) begin
                    s.s_arready = 1'b1;
                    id_d        = s.s_arid;
                    len_d       = s.s_arlen;
                    fixed_d     = s.s_arburst == 2'b00;
                    err_d       = s.s_arburst[1];
                    addr_d      = s.s_araddr[ADDR_W+1:2];
                    cnt_d       = 9'd0;
                    prio_rd_d   = 1'b0;
                    state_d     = StRdIssue;
                end else if (sel_wr) begin
                    s.s_awready = 1'b1;
                    id_d        = s.s_awid;
                    len_d       = s.s_awlen;
                    fixed_d     = s.s_awburst == 2'b00;
                    err_d       = s.s_awburst[1];
                    addr_d      = s.s_awaddr[ADDR_W+1:2];
                    cnt_d       = 9'd0;
                    prio_rd_d   = 1'b1;
                    state_d     = StWrData;
                end
            end
            StWrData: begin
                s.s_wready = 1'b1;
                if (s.s_wvalid) begin
                    ram_en = in_range;
                    ram_we = (in_range && id_ok) ? s.s_wstrb : 4'h0;
                    if (!in_range || !id_ok || (s.s_wlast && !last_beat && in_range)) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_inc;
                    if (in_range) begin
                        addr_d = addr_step;
                    end
                    if (s.s_wlast) begin
                        state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                s.s_bvalid = 1'b1;
                s.s_bresp  = err_q ? 2'b10 : 2'b00;
                if (s.s_bready) begin
                    state_d = StIdle;
                end
            end
            StRdIssue: begin
                ram_en  = 1'b1;
                state_d = StRdCap;
            end
            StRdCap: begin
                rdata_d = ram_rdata;
                state_d = StRdData;
            end
            StRdData: begin
                s.s_rvalid = 1'b1;
                s.s_rresp  = err_q ? 2'b10 : 2'b00;
                s.s_rlast  = last_beat;
                if (s.s_rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 9'd1;
                        addr_d  = addr_step;
                        state_d = StRdIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= StIdle;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            len_q     <= '0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            id_q      <= id_d;
            len_q     <= len_d;
            fixed_q   <= fixed_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s.s_awsize, s.s_arsize, s.s_awaddr[31:ADDR_W+2], s.s_awaddr[1:0],
                           s.s_araddr[31:ADDR_W+2], s.s_araddr[1:0]};

endmodule
